pwm_capture: RTL and testbench

Measures an incoming PWM waveform and reports its period and high time in clock cycles. It is the receive-side counterpart of the SOC's PWM generator: it loops back or monitors the `PWM` pin so firmware and benches can check the programmed duty cycle. Results are latched per complete period and held for a valid/acknowledge read.

---
 rtl/pwm_capture.sv | 187 ++++++++++++++++++
 tb/tb_pwm_capture.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// PWM period / high-time capture with valid/ack result handshake and stuck detection.
// Optional glitch filter on the synchronized input: define PWM_CAPTURE_FILTER_EN.
module pwm_capture #(
  parameter int WIDTH    = 16,
  parameter int FILT_LEN = 3
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             PWM_IN,
  input  logic             ACK,
  output logic [WIDTH-1:0] PERIOD,
  output logic [WIDTH-1:0] HIGH_TIME,
  output logic             VALID,
  output logic             OVERRUN,
  output logic             STUCK,
  output logic             LEVEL
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  logic             sync1, sync2;
  logic             level;
  logic             level_d;
  logic             rise_evt, fall_evt;
  logic [WIDTH-1:0] period_cnt;
  logic [WIDTH-1:0] hi_lat;
  state_t           state, state_n;
  logic             publish, latch_hi, set_stuck, clr_stuck;

  // NOTE: every clocked process uses non-blocking assignments so all flops
  // sample pre-edge values regardless of process evaluation order.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= PWM_IN;
      sync2 <= sync1;
    end
  end

`ifdef PWM_CAPTURE_FILTER_EN
  localparam int FCW = (FILT_LEN > 2) ? $clog2(FILT_LEN) : 1;

  logic [FCW-1:0] filt_cnt;
  logic           filt_level;

  // The new value must persist FILT_LEN consecutive cycles; any return to
  // the current level restarts the qualification.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      filt_cnt   <= '0;
      filt_level <= 1'b0;
    end else if (sync2 == filt_level) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FCW'(FILT_LEN - 1)) begin
      filt_level <= sync2;
      filt_cnt   <= '0;
    end else begin
      filt_cnt <= filt_cnt + FCW'(1);
    end
  end

  assign level = filt_level;
`else
  assign level = sync2;
`endif

  assign LEVEL = level;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      level_d  <= 1'b0;
      rise_evt <= 1'b0;
      fall_evt <= 1'b0;
    end else begin
      level_d  <= level;
      rise_evt <= level & ~level_d;
      fall_evt <= ~level & level_d;
    end
  end

  // Free-running saturating counter, restarted by every rise event.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      period_cnt <= '0;
    end else if (rise_evt) begin
      period_cnt <= CNT_ONE;
    end else if (period_cnt != CNT_MAX) begin
      period_cnt <= period_cnt + CNT_ONE;
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // NOTE: all outputs of this block get a default first, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    state_n   = state;
    publish   = 1'b0;
    latch_hi  = 1'b0;
    set_stuck = 1'b0;
    clr_stuck = 1'b0;
    unique case (state)
      IDLE: begin
        if (rise_evt) begin
          state_n   = HIGH;
          clr_stuck = 1'b1;
        end
      end
      HIGH: begin
        if (fall_evt) begin
          state_n  = LOW;
          latch_hi = 1'b1;
        end else if (period_cnt == CNT_MAX) begin
          state_n   = IDLE;
          set_stuck = 1'b1;
        end
      end
      LOW: begin
        if (rise_evt) begin
          state_n = HIGH;
          publish = 1'b1;
        end else if (period_cnt == CNT_MAX) begin
          state_n   = IDLE;
          set_stuck = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      hi_lat <= '0;
    end else if (latch_hi) begin
      hi_lat <= period_cnt;
    end
  end

  // A publish beats a same-cycle ACK: the fresh result stays valid and the
  // ACK still counts as consuming the old one, so no overrun is flagged.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      PERIOD    <= '0;
      HIGH_TIME <= '0;
      VALID     <= 1'b0;
      OVERRUN   <= 1'b0;
    end else if (publish) begin
      PERIOD    <= period_cnt;
      HIGH_TIME <= hi_lat;
      VALID     <= 1'b1;
      if (VALID && !ACK) begin
        OVERRUN <= 1'b1;
      end else if (VALID && ACK) begin
        OVERRUN <= 1'b0;
      end
    end else if (ACK && VALID) begin
      VALID   <= 1'b0;
      OVERRUN <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      STUCK <= 1'b0;
    end else if (set_stuck) begin
      STUCK <= 1'b1;
    end else if (clr_stuck) begin
      STUCK <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed self-checking bench for pwm_capture (WIDTH=8 so the stuck timeout is short).
module tb_pwm_capture;

  localparam int W  = 8;
  localparam int FL = 3;

  logic         CLK    = 1'b0;
  logic         RESETN = 1'b1;
  logic         PWM_IN = 1'b0;
  logic         ACK    = 1'b0;
  logic [W-1:0] PERIOD;
  logic [W-1:0] HIGH_TIME;
  logic         VALID;
  logic         OVERRUN;
  logic         STUCK;
  logic         LEVEL;

  int errors = 0;
  int checks = 0;

  pwm_capture #(.WIDTH(W), .FILT_LEN(FL)) dut (
    .CLK      (CLK),
    .RESETN   (RESETN),
    .PWM_IN   (PWM_IN),
    .ACK      (ACK),
    .PERIOD   (PERIOD),
    .HIGH_TIME(HIGH_TIME),
    .VALID    (VALID),
    .OVERRUN  (OVERRUN),
    .STUCK    (STUCK),
    .LEVEL    (LEVEL)
  );

  always #5 CLK = ~CLK;

  // Hold the pin at v for n cycles; changes land on the falling edge.
  task automatic drive(input logic v, input int n);
    PWM_IN = v;
    repeat (n) @(negedge CLK);
  endtask

  task automatic do_reset;
    ACK    = 1'b0;
    PWM_IN = 1'b0;
    @(negedge CLK);
    RESETN = 1'b0;
    repeat (3) @(negedge CLK);
    RESETN = 1'b1;
    drive(1'b0, 10);
  endtask

  task automatic test_reset;
    #2 RESETN = 1'b0;
    PWM_IN = 1'b1;
    repeat (4) @(negedge CLK);
    checks++; if (PERIOD !== 8'd0) begin errors++; $display("FAIL reset_period: got %0d expected 0", PERIOD); end
    checks++; if (HIGH_TIME !== 8'd0) begin errors++; $display("FAIL reset_high: got %0d expected 0", HIGH_TIME); end
    checks++; if ({VALID, OVERRUN, STUCK} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {VALID, OVERRUN, STUCK}); end
    checks++; if (LEVEL !== 1'b0) begin errors++; $display("FAIL reset_level: got %b expected 0", LEVEL); end
    PWM_IN = 1'b0;
    RESETN = 1'b1;
  endtask

  task automatic test_basic;
    do_reset();
    drive(1'b1, 25); drive(1'b0, 75);
    drive(1'b1, 3);
    checks++; if (VALID !== 1'b0) begin errors++; $display("FAIL basic_valid_early: got %b expected 0", VALID); end
    drive(1'b1, 1);
    checks++; if (VALID !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", VALID); end
    checks++; if (PERIOD !== 8'd100) begin errors++; $display("FAIL basic_period: got %0d expected 100", PERIOD); end
    checks++; if (HIGH_TIME !== 8'd25) begin errors++; $display("FAIL basic_high: got %0d expected 25", HIGH_TIME); end
    checks++; if (LEVEL !== 1'b1) begin errors++; $display("FAIL basic_level: got %b expected 1", LEVEL); end
    drive(1'b1, 21);
    ACK = 1'b1; drive(1'b0, 1); ACK = 1'b0;
    checks++; if ({VALID, OVERRUN} !== 2'b00) begin errors++; $display("FAIL basic_ack: got %b expected 00", {VALID, OVERRUN}); end
    drive(1'b0, 74);
    drive(1'b1, 4);
    checks++; if ({VALID, OVERRUN, PERIOD, HIGH_TIME} !== {2'b10, 8'd100, 8'd25}) begin
      errors++; $display("FAIL basic_third: got v=%b o=%b %0d/%0d expected v=1 o=0 100/25", VALID, OVERRUN, PERIOD, HIGH_TIME);
    end
    drive(1'b1, 21); drive(1'b0, 5);
  endtask

  task automatic test_overrun;
    do_reset();
    drive(1'b1, 10); drive(1'b0, 30);
    drive(1'b1, 4);
    checks++; if ({VALID, OVERRUN, PERIOD, HIGH_TIME} !== {2'b10, 8'd40, 8'd10}) begin
      errors++; $display("FAIL ovr_first: got v=%b o=%b %0d/%0d expected v=1 o=0 40/10", VALID, OVERRUN, PERIOD, HIGH_TIME);
    end
    drive(1'b1, 6); drive(1'b0, 30);
    drive(1'b1, 4);
    checks++; if ({VALID, OVERRUN} !== 2'b11) begin errors++; $display("FAIL ovr_set: got %b expected 11", {VALID, OVERRUN}); end
    drive(1'b1, 11); drive(1'b0, 45);
    drive(1'b1, 4);
    checks++; if ({OVERRUN, PERIOD, HIGH_TIME} !== {1'b1, 8'd60, 8'd15}) begin
      errors++; $display("FAIL ovr_latest: got o=%b %0d/%0d expected o=1 60/15", OVERRUN, PERIOD, HIGH_TIME);
    end
    ACK = 1'b1; drive(1'b1, 1); ACK = 1'b0;
    checks++; if ({VALID, OVERRUN} !== 2'b00) begin errors++; $display("FAIL ovr_ack: got %b expected 00", {VALID, OVERRUN}); end
  endtask

  task automatic test_back_to_back;
    do_reset();
    drive(1'b1, 10); drive(1'b0, 30);
    drive(1'b1, 10); drive(1'b0, 30);
    drive(1'b1, 3);
    ACK = 1'b1; drive(1'b1, 1); ACK = 1'b0;
    checks++; if ({VALID, OVERRUN} !== 2'b10) begin errors++; $display("FAIL simul_ack: got %b expected 10", {VALID, OVERRUN}); end
    drive(1'b1, 1);
    checks++; if ({VALID, OVERRUN} !== 2'b10) begin errors++; $display("FAIL simul_hold: got %b expected 10", {VALID, OVERRUN}); end
    drive(1'b1, 5); drive(1'b0, 5);
  endtask

  task automatic test_stuck;
    do_reset();
    drive(1'b1, 10); drive(1'b0, 30);
    drive(1'b1, 4);
    checks++; if ({VALID, PERIOD, HIGH_TIME} !== {1'b1, 8'd40, 8'd10}) begin
      errors++; $display("FAIL stuck_pre: got v=%b %0d/%0d expected v=1 40/10", VALID, PERIOD, HIGH_TIME);
    end
    drive(1'b1, 254);
    checks++; if (STUCK !== 1'b0) begin errors++; $display("FAIL stuck_early: got %b expected 0", STUCK); end
    drive(1'b1, 1);
    checks++; if ({STUCK, LEVEL} !== 2'b11) begin errors++; $display("FAIL stuck_set: got %b expected 11", {STUCK, LEVEL}); end
    checks++; if ({PERIOD, HIGH_TIME} !== {8'd40, 8'd10}) begin errors++; $display("FAIL stuck_hold: got %0d/%0d expected 40/10", PERIOD, HIGH_TIME); end
    drive(1'b0, 30);
    checks++; if ({STUCK, LEVEL} !== 2'b10) begin errors++; $display("FAIL stuck_low: got %b expected 10", {STUCK, LEVEL}); end
    drive(1'b1, 4);
    checks++; if ({STUCK, PERIOD} !== {1'b0, 8'd40}) begin errors++; $display("FAIL stuck_clear: got s=%b p=%0d expected s=0 p=40", STUCK, PERIOD); end
    drive(1'b1, 16); drive(1'b0, 30);
    drive(1'b1, 4);
    checks++; if ({PERIOD, HIGH_TIME} !== {8'd50, 8'd20}) begin errors++; $display("FAIL stuck_resume: got %0d/%0d expected 50/20", PERIOD, HIGH_TIME); end
    drive(1'b1, 16); drive(1'b0, 5);
  endtask

  task automatic test_reset_mid;
    do_reset();
    drive(1'b1, 10); drive(1'b0, 30);
    drive(1'b1, 5);
    #2 RESETN = 1'b0;
    #1;
    checks++; if ({VALID, OVERRUN, STUCK, LEVEL, PERIOD, HIGH_TIME} !== 20'd0) begin
      errors++; $display("FAIL rmid_async: got v=%b o=%b s=%b l=%b %0d/%0d expected all 0", VALID, OVERRUN, STUCK, LEVEL, PERIOD, HIGH_TIME);
    end
    @(negedge CLK);
    RESETN = 1'b1;
    drive(1'b1, 5); drive(1'b0, 30);
    checks++; if (VALID !== 1'b0) begin errors++; $display("FAIL rmid_first: got %b expected 0", VALID); end
    drive(1'b1, 3);
    checks++; if (VALID !== 1'b0) begin errors++; $display("FAIL rmid_early: got %b expected 0", VALID); end
    drive(1'b1, 1);
    checks++; if ({VALID, PERIOD, HIGH_TIME} !== {1'b1, 8'd35, 8'd5}) begin
      errors++; $display("FAIL rmid_pub: got v=%b %0d/%0d expected v=1 35/5", VALID, PERIOD, HIGH_TIME);
    end
    drive(1'b1, 1); drive(1'b0, 5);
  endtask

  task automatic test_glitch;
    logic [W-1:0] exp_p, exp_h;
    logic         exp_o;
`ifdef PWM_CAPTURE_FILTER_EN
    exp_p = 8'd100; exp_h = 8'd30; exp_o = 1'b0;
`else
    exp_p = 8'd87;  exp_h = 8'd17; exp_o = 1'b1;
`endif
    do_reset();
    drive(1'b1, 30); drive(1'b0, 70);
    drive(1'b1, 10);
    checks++; if ({VALID, PERIOD, HIGH_TIME} !== {1'b1, 8'd100, 8'd30}) begin
      errors++; $display("FAIL glitch_clean: got v=%b %0d/%0d expected v=1 100/30", VALID, PERIOD, HIGH_TIME);
    end
    ACK = 1'b1; drive(1'b1, 1); ACK = 1'b0;
    drive(1'b0, 2);
    drive(1'b1, 17); drive(1'b0, 70);
    drive(1'b1, 10);
    checks++; if ({PERIOD, HIGH_TIME} !== {exp_p, exp_h}) begin
      errors++; $display("FAIL glitch_result: got %0d/%0d expected %0d/%0d", PERIOD, HIGH_TIME, exp_p, exp_h);
    end
    checks++; if (OVERRUN !== exp_o) begin errors++; $display("FAIL glitch_overrun: got %b expected %b", OVERRUN, exp_o); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_back_to_back();
    test_stuck();
    test_reset_mid();
    test_glitch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
